// File: rtl/dec_pipe.sv
// -----------------------------------------------------------------------------
// dec_pipe -- decode stage of an in-order pipeline.
//
// This stage holds a 16-entry register file with two combinational read
// ports and one synchronous write port, which the writeback stage drives. It
// accepts one instruction per cycle from FETCH and decodes it into a single
// output register for EXE. A valid/ready handshake sits on each side.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   in_valid/in_ready FETCH handshake (in_ready is combinational)
//   instruction       opcode[31:28] rd[27:24] rs1[23:20] rs2[19:16] imm[15:0]
//   pc_in             PC of the presented instruction
//   wb_wen/addr/data  register-file write port from WB
//   flush             discard the held bundle and refuse the incoming one
//   out_valid/ready   EXE handshake
//   rs1_val, rs2_val  operand values (bypassed from WB; refreshed while held)
//   rs1, rs2, rd      register fields
//   instr_type        opcode[3:2]
//   is_computational  opcode[1]
//   is_load_store     opcode[0]
//   se_imm            imm sign-extended to XLEN
//   pc_out            registered PC
//
// Parameters
//   XLEN      data/PC width, must be >= 16
//   ZERO_REG  when 1, r0 reads as zero and writes to r0 are discarded
// -----------------------------------------------------------------------------
module dec_pipe #(
    parameter int XLEN     = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc_in,

    input  logic            wb_wen,
    input  logic [3:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,

    input  logic            flush,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rs1_val,
    output logic [XLEN-1:0] rs2_val,
    output logic [3:0]      rs1,
    output logic [3:0]      rs2,
    output logic [3:0]      rd,
    output logic [1:0]      instr_type,
    output logic            is_computational,
    output logic            is_load_store,
    output logic [XLEN-1:0] se_imm,
    output logic [XLEN-1:0] pc_out
);

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [3:0]  f_opcode, f_rd, f_rs1, f_rs2;
    logic [15:0] f_imm;

    assign f_opcode = instruction[31:28];
    assign f_rd     = instruction[27:24];
    assign f_rs1    = instruction[23:20];
    assign f_rs2    = instruction[19:16];
    assign f_imm    = instruction[15:0];

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rf_q [16];

    // A write to r0 is dropped when ZERO_REG is set. r0 then stays at its
    // reset value of zero, so reads of r0 need no special case. Only the
    // bypass and refresh paths have to ignore such a write.
    logic wb_live;
    assign wb_live = wb_wen && !(ZERO_REG && (wb_addr == 4'd0));

    // NOTE: the register file is reset here because every entry must read as
    //       zero right after reset. A RAM that never needs a known start
    //       value would normally be left out of the reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_live) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    // Operand read with WB bypass. A write landing this cycle wins over the
    // stale entry, so the accepted bundle never carries the old value.
    logic [XLEN-1:0] rd1_val, rd2_val;

    always_comb begin
        rd1_val = rf_q[f_rs1];
        rd2_val = rf_q[f_rs2];
        if (wb_live && (wb_addr == f_rs1)) rd1_val = wb_data;
        if (wb_live && (wb_addr == f_rs2)) rd2_val = wb_data;
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic valid_q, valid_d;
    logic accept;

    assign in_ready = !flush && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rs1_val_q, rs1_val_d;
    logic [XLEN-1:0] rs2_val_q, rs2_val_d;
    logic [3:0]      rs1_q, rs1_d;
    logic [3:0]      rs2_q, rs2_d;
    logic [3:0]      rd_q, rd_d;
    logic [1:0]      type_q, type_d;
    logic            comp_q, comp_d;
    logic            ls_q, ls_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] pc_q, pc_d;

    // NOTE: every next-state value gets its hold default before any branch,
    //       so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        valid_d   = valid_q;
        rs1_val_d = rs1_val_q;
        rs2_val_d = rs2_val_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        type_d    = type_q;
        comp_d    = comp_q;
        ls_d      = ls_q;
        imm_d     = imm_q;
        pc_d      = pc_q;

        if (flush) begin
            // Data fields become don't-care once the valid bit drops.
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d   = 1'b1;
            rs1_val_d = rd1_val;
            rs2_val_d = rd2_val;
            rs1_d     = f_rs1;
            rs2_d     = f_rs2;
            rd_d      = f_rd;
            type_d    = f_opcode[3:2];
            comp_d    = f_opcode[1];
            ls_d      = f_opcode[0];
            imm_d     = XLEN'(signed'(f_imm));
            pc_d      = pc_in;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            // The bundle is stalled. A WB write to one of its source
            // registers is folded in so that EXE sees the newest value.
            if (wb_live && (wb_addr == rs1_q)) rs1_val_d = wb_data;
            if (wb_live && (wb_addr == rs2_q)) rs2_val_d = wb_data;
        end
    end

    // NOTE: state registers use non-blocking assignments only. That way
    //       every flop samples values from before the edge, whatever order
    //       the blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            rs1_val_q <= '0;
            rs2_val_q <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            type_q    <= '0;
            comp_q    <= 1'b0;
            ls_q      <= 1'b0;
            imm_q     <= '0;
            pc_q      <= '0;
        end else begin
            valid_q   <= valid_d;
            rs1_val_q <= rs1_val_d;
            rs2_val_q <= rs2_val_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            type_q    <= type_d;
            comp_q    <= comp_d;
            ls_q      <= ls_d;
            imm_q     <= imm_d;
            pc_q      <= pc_d;
        end
    end

    assign out_valid        = valid_q;
    assign rs1_val          = rs1_val_q;
    assign rs2_val          = rs2_val_q;
    assign rs1              = rs1_q;
    assign rs2              = rs2_q;
    assign rd               = rd_q;
    assign instr_type       = type_q;
    assign is_computational = comp_q;
    assign is_load_store    = ls_q;
    assign se_imm           = imm_q;
    assign pc_out           = pc_q;

endmodule
